// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide engine (radix-2 shift-add
// multiply, restoring divide), one iteration per clock, XLEN+2 cycle latency.
// Optional macro MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and
// multiply-by-zero skip the iterations and finish one cycle after START.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            START,
  input  logic [2:0]      OP,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned AW = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, FINISH} state_t;

  state_t          state;
  logic [2:0]      op_q;
  logic            sign1;
  logic            sign2;
  logic            div0;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   acc;    // multiply: product; divide: {remainder, quotient}
  logic [AW-1:0]   mcand;  // shifted multiplicand
  logic [XLEN-1:0] opb;    // multiplier (shifted) or divisor (static)

  logic            in_s1;
  logic            in_s2;
  logic [XLEN-1:0] abs1;
  logic [XLEN-1:0] abs2;
  logic [XLEN:0]   trial;
  logic [AW-1:0]   prod;
  logic [XLEN-1:0] quot;
  logic [XLEN-1:0] remv;
  logic [XLEN-1:0] fix_res;
  logic            accept;

  // Operand sign capture and magnitude conversion at request time
  always_comb begin
    in_s1 = ((OP == 3'b001) || (OP == 3'b010) || (OP == 3'b100) || (OP == 3'b110))
            && DATA1[XLEN-1];
    in_s2 = ((OP == 3'b001) || (OP == 3'b100) || (OP == 3'b110)) && DATA2[XLEN-1];
    abs1  = in_s1 ? (XLEN'(0) - DATA1) : DATA1;
    abs2  = in_s2 ? (XLEN'(0) - DATA2) : DATA2;
  end

  // Trial subtraction for the restoring divide step; bit XLEN is the borrow
  always_comb begin
    trial = acc[AW-1:XLEN-1] - {1'b0, opb};
  end

  // Sign correction and result selection; zero divisor forces all-ones quotient
  always_comb begin
    prod = (sign1 ^ sign2) ? (AW'(0) - acc) : acc;
    if (div0)
      quot = '1;
    else
      quot = (sign1 ^ sign2) ? (XLEN'(0) - acc[XLEN-1:0]) : acc[XLEN-1:0];
    remv = sign1 ? (XLEN'(0) - acc[AW-1:XLEN]) : acc[AW-1:XLEN];
    case (op_q)
      3'b000:                 fix_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[AW-1:XLEN];
      3'b100, 3'b101:         fix_res = quot;
      default:                fix_res = remv;
    endcase
  end

  assign accept = START && !FLUSH && ((state == IDLE) || (state == FINISH));

`ifdef MULDIV_EARLY_OUT_EN
  logic            early_hit;
  logic [XLEN-1:0] early_val;
  logic            early_q;
  logic [XLEN-1:0] early_val_q;

  // Detect operations whose result is known without iterating
  always_comb begin
    early_hit = 1'b0;
    early_val = '0;
    if (OP[2]) begin
      if (DATA2 == '0) begin
        early_hit = 1'b1;
        early_val = OP[1] ? DATA1 : '1;
      end else if (!OP[0] && (DATA1 == {1'b1, {(XLEN-1){1'b0}}}) && (DATA2 == '1)) begin
        early_hit = 1'b1;
        early_val = OP[1] ? '0 : DATA1;
      end
    end else if ((DATA1 == '0) || (DATA2 == '0)) begin
      early_hit = 1'b1;
    end
  end
`endif

  // Control FSM, datapath iteration and registered outputs
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= IDLE;
      op_q   <= '0;
      sign1  <= 1'b0;
      sign2  <= 1'b0;
      div0   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      opb    <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      RESULT <= '0;
`ifdef MULDIV_EARLY_OUT_EN
      early_q     <= 1'b0;
      early_val_q <= '0;
`endif
    end else if (FLUSH && (state != IDLE)) begin
      state <= IDLE;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          BUSY <= 1'b0;
        end
        CALC: begin
          BUSY <= 1'b1;
          if (op_q[2]) begin
            if (!trial[XLEN])
              acc <= {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
              acc <= {acc[AW-2:0], 1'b0};
          end else begin
            if (opb[0])
              acc <= acc + mcand;
            mcand <= {mcand[AW-2:0], 1'b0};
            opb   <= {1'b0, opb[XLEN-1:1]};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(XLEN - 1))
            state <= FIXUP;
        end
        FIXUP: begin
          BUSY   <= 1'b1;
          RESULT <= fix_res;
          state  <= FINISH;
        end
        FINISH: begin
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
          state <= IDLE;
`ifdef MULDIV_EARLY_OUT_EN
          if (early_q)
            RESULT <= early_val_q;
`endif
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        op_q  <= OP;
        sign1 <= in_s1;
        sign2 <= in_s2;
        div0  <= (DATA2 == '0);
        cnt   <= '0;
        opb   <= abs2;
        if (OP[2]) begin
          acc   <= {{XLEN{1'b0}}, abs1};
          mcand <= '0;
        end else begin
          acc   <= '0;
          mcand <= {{XLEN{1'b0}}, abs1};
        end
`ifdef MULDIV_EARLY_OUT_EN
        early_q     <= early_hit;
        early_val_q <= early_val;
        state       <= early_hit ? FINISH : CALC;
`else
        state <= CALC;
`endif
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 34;
`endif

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        START;
  logic [2:0]  OP;
  logic [31:0] DATA1;
  logic [31:0] DATA2;
  logic        FLUSH;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .OP(OP),
    .DATA1(DATA1), .DATA2(DATA2), .FLUSH(FLUSH),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
  );

  always #5 CLK = ~CLK;

  // Issue one operation and wait for DONE (bounded); optionally pulse a stray START mid-flight
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, output logic [31:0] res, output int lat,
                        output int busy_n);
    START = 1'b1; OP = op; DATA1 = a; DATA2 = b;
    @(posedge CLK); #1;
    START = 1'b0; OP = 3'b000; DATA1 = 32'hDEAD_BEEF; DATA2 = 32'h0000_1234;
    lat = 0; busy_n = 0; res = 32'h0;
    for (int j = 1; j <= 100; j++) begin
      @(posedge CLK); #1;
      START = disturb && (j == 3);
      if (BUSY) busy_n++;
      if (DONE) begin
        lat = j;
        res = RESULT;
        break;
      end
    end
    START = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; START = 1'b0; FLUSH = 1'b0; OP = 3'b000; DATA1 = '0; DATA2 = '0;
    repeat (3) @(posedge CLK);
    #1;
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", DONE); end
    total++; if (RESULT !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 0", RESULT); end
    RESET_N = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_mul();
    logic [31:0] r; int lat; int bn;
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0, r, lat, bn);
    total++; if (r !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mul_result: got %h want ffffffeb", r); end
    total++; if (lat != 34) begin bad++; $display("FAIL mul_latency: got %0d want 34", lat); end
    total++; if (bn != 33) begin bad++; $display("FAIL mul_busy_cycles: got %0d want 33", bn); end
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 1'b0, r, lat, bn);
    total++; if (r !== 32'h4000_0000 || lat != 34) begin bad++; $display("FAIL mulh: got %h/%0d want 40000000/34", r, lat); end
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, r, lat, bn);
    total++; if (r !== 32'hFFFF_FFFF || lat != 34) begin bad++; $display("FAIL mulhsu: got %h/%0d want ffffffff/34", r, lat); end
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, r, lat, bn);
    total++; if (r !== 32'hFFFF_FFFE || lat != 34) begin bad++; $display("FAIL mulhu: got %h/%0d want fffffffe/34", r, lat); end
  endtask

  task automatic test_div();
    logic [31:0] r; int lat; int bn;
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0, r, lat, bn);
    total++; if (r !== 32'hFFFF_FFFD || lat != 34) begin bad++; $display("FAIL div_neg: got %h/%0d want fffffffd/34", r, lat); end
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0, r, lat, bn);
    total++; if (r !== 32'hFFFF_FFFF || lat != 34) begin bad++; $display("FAIL rem_neg: got %h/%0d want ffffffff/34", r, lat); end
    run_op(3'b101, 32'd100, 32'd7, 1'b0, r, lat, bn);
    total++; if (r !== 32'd14 || lat != 34) begin bad++; $display("FAIL divu: got %h/%0d want 0000000e/34", r, lat); end
    run_op(3'b111, 32'd100, 32'd7, 1'b0, r, lat, bn);
    total++; if (r !== 32'd2 || lat != 34) begin bad++; $display("FAIL remu: got %h/%0d want 00000002/34", r, lat); end
  endtask

  task automatic test_special();
    logic [31:0] r; int lat; int bn;
    run_op(3'b101, 32'd5, 32'd0, 1'b0, r, lat, bn);
    total++; if (r !== 32'hFFFF_FFFF || lat != SPEC_LAT) begin bad++; $display("FAIL divu_by_zero: got %h/%0d want ffffffff/%0d", r, lat, SPEC_LAT); end
    run_op(3'b111, 32'd5, 32'd0, 1'b0, r, lat, bn);
    total++; if (r !== 32'd5 || lat != SPEC_LAT) begin bad++; $display("FAIL remu_by_zero: got %h/%0d want 00000005/%0d", r, lat, SPEC_LAT); end
    run_op(3'b100, 32'hFFFF_FFF9, 32'd0, 1'b0, r, lat, bn);
    total++; if (r !== 32'hFFFF_FFFF || lat != SPEC_LAT) begin bad++; $display("FAIL div_neg_by_zero: got %h/%0d want ffffffff/%0d", r, lat, SPEC_LAT); end
    run_op(3'b110, 32'hFFFF_FFF9, 32'd0, 1'b0, r, lat, bn);
    total++; if (r !== 32'hFFFF_FFF9 || lat != SPEC_LAT) begin bad++; $display("FAIL rem_neg_by_zero: got %h/%0d want fffffff9/%0d", r, lat, SPEC_LAT); end
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, r, lat, bn);
    total++; if (r !== 32'h8000_0000 || lat != SPEC_LAT) begin bad++; $display("FAIL div_overflow: got %h/%0d want 80000000/%0d", r, lat, SPEC_LAT); end
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, r, lat, bn);
    total++; if (r !== 32'h0 || lat != SPEC_LAT) begin bad++; $display("FAIL rem_overflow: got %h/%0d want 00000000/%0d", r, lat, SPEC_LAT); end
    total++; if (SPEC_LAT == 1 && bn != 0) begin bad++; $display("FAIL early_busy: got %0d busy cycles want 0", bn); end
    run_op(3'b000, 32'd0, 32'd123, 1'b0, r, lat, bn);
    total++; if (r !== 32'h0 || lat != SPEC_LAT) begin bad++; $display("FAIL mul_zero: got %h/%0d want 00000000/%0d", r, lat, SPEC_LAT); end
  endtask

  task automatic test_flush();
    logic [31:0] r; int lat; int bn; logic [31:0] prev; bit saw_done;
    run_op(3'b111, 32'd100, 32'd7, 1'b0, r, lat, bn);
    prev = 32'd2;
    START = 1'b1; OP = 3'b000; DATA1 = 32'd5; DATA2 = 32'd6;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (9) begin @(posedge CLK); #1; end
    FLUSH = 1'b1;
    @(posedge CLK); #1;
    FLUSH = 1'b0;
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b want 0", BUSY); end
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (DONE) saw_done = 1'b1;
    end
    total++; if (saw_done) begin bad++; $display("FAIL flush_no_done: got done=1 want 0"); end
    total++; if (RESULT !== prev) begin bad++; $display("FAIL flush_result_kept: got %h want %h", RESULT, prev); end
    START = 1'b1; FLUSH = 1'b1; OP = 3'b101; DATA1 = 32'd9; DATA2 = 32'd3;
    @(posedge CLK); #1;
    START = 1'b0; FLUSH = 1'b0;
    total++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin bad++; $display("FAIL start_flush_idle: got busy=%b done=%b want 0/0", BUSY, DONE); end
    run_op(3'b101, 32'd9, 32'd3, 1'b1, r, lat, bn);
    total++; if (r !== 32'd3 || lat != 34) begin bad++; $display("FAIL divu_after_flush: got %h/%0d want 00000003/34", r, lat); end
  endtask

  task automatic test_back_to_back();
    int lat;
    START = 1'b1; OP = 3'b000; DATA1 = 32'd3; DATA2 = 32'd5;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (33) begin @(posedge CLK); #1; end
    START = 1'b1; OP = 3'b101; DATA1 = 32'd100; DATA2 = 32'd7;
    @(posedge CLK); #1;
    START = 1'b0;
    total++; if (DONE !== 1'b1 || RESULT !== 32'd15) begin bad++; $display("FAIL b2b_first: got done=%b %h want 1/0000000f", DONE, RESULT); end
    lat = 0;
    for (int j = 1; j <= 100; j++) begin
      @(posedge CLK); #1;
      if (DONE) begin lat = j; break; end
    end
    total++; if (RESULT !== 32'd14 || lat != 34) begin bad++; $display("FAIL b2b_second: got %h/%0d want 0000000e/34", RESULT, lat); end
  endtask

  task automatic test_async_reset();
    logic [31:0] r; int lat; int bn;
    START = 1'b1; OP = 3'b000; DATA1 = 32'd11; DATA2 = 32'd13;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (5) begin @(posedge CLK); #1; end
    #2 RESET_N = 1'b0;
    #1;
    total++; if (BUSY !== 1'b0 || DONE !== 1'b0 || RESULT !== 32'h0) begin bad++; $display("FAIL async_reset: got busy=%b done=%b %h want 0/0/00000000", BUSY, DONE, RESULT); end
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    run_op(3'b000, 32'd3, 32'd4, 1'b0, r, lat, bn);
    total++; if (r !== 32'd12 || lat != 34) begin bad++; $display("FAIL mul_after_reset: got %h/%0d want 0000000c/34", r, lat); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multi-cycle RV32M multiply/divide engine; the sequential responder to the EX stage's M-extension requests.
- EX stage issues a START with operands and funct3.
- Unit runs radix-2 shift-add (multiply) or restoring division, raises BUSY while working, and pulses DONE with RESULT.
- Pipeline control stalls on BUSY. Replaces single-cycle combinational mul/div paths on timing-critical builds.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
CLK  input  1  clock, rising-edge.
RESET_N  input  1  asynchronous active-low reset.
START  input  1  request strobe; sampled only when BUSY=0.
OP  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
DATA1  input  XLEN  rs1 operand (multiplicand / dividend).
DATA2  input  XLEN  rs2 operand (multiplier / divisor).
FLUSH  input  1  synchronous abort of in-flight operation.
BUSY  output  1  high from cycle after START acceptance until DONE cycle.
DONE  output  1  one-cycle pulse, RESULT valid.
RESULT  output  XLEN  result; held until the next DONE or reset.

Behaviour:
- Reset: RESET_N low asynchronously forces IDLE, BUSY=0, DONE=0, RESULT=0, clears all internal registers. Mid-operation reset discards the operation.
- States: IDLE, CALC, FIXUP, FINISH.
- IDLE, START=1, FLUSH=0 at edge k:
  - Latch OP, DATA1, DATA2.
  - Record operand signs. Signed: DATA1 for MULH/MULHSU/DIV/REM; DATA2 for MULH/DIV/REM.
  - Latch absolute values. Iteration counter = 0. Go to CALC.
- CALC: one iteration per cycle for XLEN cycles (edges k+1..k+32).
  - Multiply: 2*XLEN-bit accumulator; add shifted multiplicand when current multiplier bit is 1.
  - Divide: shift remainder left, subtract divisor if no borrow, set quotient bit.
  - Counter reaching XLEN-1 -> FIXUP.
- FIXUP (edge k+33): apply sign correction.
  - Product negated if sign1^sign2.
  - Quotient negated if sign1^sign2; remainder negated if sign1.
  - Select MUL=low word; MULH/MULHSU/MULHU=high word; DIV/DIVU=quotient; REM/REMU=remainder.
  - Write RESULT. Go to FINISH.
- FINISH: DONE=1, BUSY=0 for exactly one cycle (after edge k+34), then IDLE. Total latency START edge -> DONE = XLEN+2 cycles.
- BUSY=1 in CALC and FIXUP only.
- Back-to-back: START is accepted in the FINISH cycle, so there are no dead cycles between operations.
- Operand changes after acceptance have no effect. START while BUSY=1 is ignored.
- Divide by zero (RISC-V defined): DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> DATA1 unmodified.
- Signed overflow (DIV, DATA1=0x80000000, DATA2=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- Special-case results are produced via full-latency path unless the optional feature is enabled; values are identical either way.
- FLUSH=1 at any edge in CALC/FIXUP/FINISH -> IDLE next edge. DONE not pulsed (FINISH cancels the pulse). RESULT unchanged.
- START and FLUSH asserted together in IDLE: FLUSH wins, no operation accepted.
- Width rules: all internal negation in two's complement at 2*XLEN (multiply) or XLEN+1 (divide) bits. No X propagation from unused accumulator bits.

Optional Feature:
Macro MULDIV_EARLY_OUT_EN.
- Defined: divide-by-zero, signed overflow, and multiply with either operand zero bypass CALC.
  - Go IDLE -> FINISH directly; DONE one cycle after START edge with the correct special value.
  - BUSY stays 0 for these operations.
- Undefined: every operation takes exactly XLEN+2 cycles; results are identical.

Test Plan:
- MUL DATA1=7, DATA2=0xFFFFFFFD -> RESULT=0xFFFFFFEB; DONE exactly 34 cycles after START; BUSY high 33 cycles.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0. With MULDIV_EARLY_OUT_EN these DONE 1 cycle after START; without, 34 cycles.
- START MUL, FLUSH at 10th CALC cycle -> BUSY=0 next cycle, no DONE, RESULT keeps previous value. START ignored while BUSY. New DIVU 9/3 afterward -> 3 in 34 cycles.
- RESET_N low mid-CALC (asynchronously, between edges) -> BUSY=DONE=0, RESULT=0 immediately. After release, MUL 3x4 -> 12 with normal latency.
